// File: rtl/lfsr_seq_pkg.sv
// Shared types and constants for the LFSR sequence controller and its 4-bit core.
// Optional zero-seed rejection is built with LFSR_SEQ_ZERO_GUARD_EN.
package lfsr_seq_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StLoad = 2'd1,
      StRun  = 2'd2,
      StDone = 2'd3
   } state_e;

   localparam int unsigned LfsrWidth     = 4;
   localparam int unsigned TapHi         = 3;
   localparam int unsigned TapLo         = 2;
   localparam int unsigned MaxLenDefault = 16;
   localparam int unsigned LenWidth      = 5;
   localparam int unsigned DataWidth     = 16;

   // Feedback and output bit share the same taps.
   function automatic logic lfsr_fb(input logic [LfsrWidth-1:0] s);
      return s[TapHi] ^ s[TapLo];
   endfunction

   function automatic logic [LfsrWidth-1:0] lfsr_next(input logic [LfsrWidth-1:0] s);
      return {s[LfsrWidth-2:0], lfsr_fb(s)};
   endfunction

endpackage

// File: rtl/lfsr4_core.sv
// 4-bit Fibonacci LFSR with synchronous load and clock enable.
// Load takes priority over stepping; state holds when neither is asserted.
module lfsr4_core
   import lfsr_seq_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic                 load,
   input  logic [LfsrWidth-1:0] seed,
   output logic [LfsrWidth-1:0] state,
   output logic                 out_bit
);

   logic [LfsrWidth-1:0] state_q;
   logic [LfsrWidth-1:0] state_d;

   always_comb begin
      state_d = state_q;
      if (load) begin
         state_d = seed;
      end else if (en) begin
         state_d = lfsr_next(state_q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= '0;
      end else begin
         state_q <= state_d;
      end
   end

   assign state   = state_q;
   assign out_bit = lfsr_fb(state_q);

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Command-driven LFSR bit collector: load a seed, shift out cmd_len bits, return them.
// Define LFSR_SEQ_ZERO_GUARD_EN to reject the all-zero (lock-up) seed.
module lfsr_seq_ctrl
   import lfsr_seq_pkg::*;
#(
   parameter int unsigned MAX_LEN = MaxLenDefault
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [LfsrWidth-1:0] cmd_seed,
   input  logic [LenWidth-1:0]  cmd_len,
   input  logic                 abort,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [DataWidth-1:0] rsp_data,
   output logic                 rsp_err,
   output logic                 busy
);

   state_e state_q;
   state_e state_d;

   logic [LfsrWidth-1:0] seed_q;
   logic [LenWidth-1:0]  cnt_q;
   logic [DataWidth-1:0] collect_q;
   logic                 err_q;

   logic                 accept;
   logic                 len_bad;
   logic                 cmd_bad;
   logic                 core_en;
   logic                 core_load;
   logic [LfsrWidth-1:0] core_state;
   logic                 core_bit;

   assign len_bad = (cmd_len == '0) || (32'(cmd_len) > MAX_LEN);

`ifdef LFSR_SEQ_ZERO_GUARD_EN
   assign cmd_bad = len_bad || (cmd_seed == '0);
`else
   assign cmd_bad = len_bad;
`endif

   assign accept = cmd_valid && cmd_ready;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; abort wins over completion in LOAD and RUN.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (cmd_valid) begin
               state_d = cmd_bad ? StDone : StLoad;
            end
         end
         StLoad: begin
            state_d = abort ? StIdle : StRun;
         end
         StRun: begin
            if (abort) begin
               state_d = StIdle;
            end else if (cnt_q == LenWidth'(1)) begin
               state_d = StDone;
            end
         end
         StDone: begin
            if (rsp_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Output decode
   always_comb begin
      cmd_ready = 1'b0;
      busy      = 1'b1;
      rsp_valid = 1'b0;
      core_load = 1'b0;
      core_en   = 1'b0;
      unique case (state_q)
         StIdle: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
         end
         StLoad: core_load = 1'b1;
         StRun:  core_en   = 1'b1;
         StDone: rsp_valid = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seed_q    <= '0;
         cnt_q     <= '0;
         collect_q <= '0;
         err_q     <= 1'b0;
      end else if (accept) begin
         seed_q    <= cmd_seed;
         cnt_q     <= cmd_len;
         collect_q <= '0;
         err_q     <= cmd_bad;
      end else if (core_en) begin
         collect_q <= {collect_q[DataWidth-2:0], core_bit};
         cnt_q     <= cnt_q - LenWidth'(1);
      end
   end

   assign rsp_data = collect_q;
   assign rsp_err  = err_q && rsp_valid;

   lfsr4_core u_core (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (core_en),
      .load    (core_load),
      .seed    (seed_q),
      .state   (core_state),
      .out_bit (core_bit)
   );

   // The core always holds the latched seed the cycle after LOAD.
   a_load_seed : assert property (@(posedge clk) disable iff (!rst_n)
      (state_q == StLoad) |=> (core_state == seed_q));

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Randomized self-checking bench for lfsr_seq_ctrl against a bit-level LFSR model.
// Honors LFSR_SEQ_ZERO_GUARD_EN in the expected responses.
module tb_lfsr_seq_ctrl;

   localparam int unsigned MaxLen = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [3:0]  cmd_seed = '0;
   logic [4:0]  cmd_len = '0;
   logic        abort = 1'b0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [15:0] rsp_data;
   logic        rsp_err;
   logic        busy;

   int total = 0;
   int bad   = 0;

   lfsr_seq_ctrl #(.MAX_LEN(MaxLen)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_seed  (cmd_seed),
      .cmd_len   (cmd_len),
      .abort     (abort),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Expected response from the stated rules: out bit = s3^s2, shift left, first bit ends MSB.
   task automatic model(input logic [3:0] seed, input logic [4:0] len,
                        output logic err, output logic [15:0] data);
      int s;
      int d;
      int b;
      bit guard;
`ifdef LFSR_SEQ_ZERO_GUARD_EN
      guard = 1'b1;
`else
      guard = 1'b0;
`endif
      err  = 1'b0;
      data = '0;
      if (len == 0 || int'(len) > MaxLen || (guard && seed == 0)) begin
         err = 1'b1;
      end else begin
         s = int'(seed);
         d = 0;
         for (int i = 0; i < int'(len); i++) begin
            b = ((s >> 3) ^ (s >> 2)) & 1;
            d = (d * 2) + b;
            s = ((s * 2) + b) % 16;
         end
         data = 16'(d);
      end
   endtask

   task automatic run_cmd(input logic [3:0] seed, input logic [4:0] len, input int hold,
                          input string tag);
      logic        exp_err;
      logic [15:0] exp_data;
      int          lat;
      model(seed, len, exp_err, exp_data);
      rsp_ready = (hold == 0);
      @(negedge clk);
      check_eq({tag, ":ready"}, 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1;
      cmd_seed  = seed;
      cmd_len   = len;
      abort     = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      abort     = 1'b0;
      cmd_seed  = 4'($urandom);
      cmd_len   = 5'($urandom);
      lat = 1;
      while (!rsp_valid && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check_eq({tag, ":lat"}, 32'(lat), exp_err ? 32'd1 : 32'(len) + 32'd2);
      check_eq({tag, ":data"}, 32'(rsp_data), 32'(exp_data));
      check_eq({tag, ":err"}, 32'(rsp_err), 32'(exp_err));
      check_eq({tag, ":done_rdy"}, 32'(cmd_ready), 32'd0);
      for (int i = 0; i < hold; i++) begin
         cmd_valid = 1'($urandom_range(0, 1));
         cmd_seed  = 4'($urandom);
         cmd_len   = 5'($urandom_range(1, 16));
         abort     = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
         check_eq({tag, ":hold_v"}, 32'(rsp_valid), 32'd1);
         check_eq({tag, ":hold_d"}, 32'(rsp_data), 32'(exp_data));
         check_eq({tag, ":hold_e"}, 32'(rsp_err), 32'(exp_err));
         check_eq({tag, ":hold_r"}, 32'(cmd_ready), 32'd0);
      end
      cmd_valid = 1'b0;
      abort     = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      check_eq({tag, ":ack_v"}, 32'(rsp_valid), 32'd0);
      check_eq({tag, ":ack_r"}, 32'(cmd_ready), 32'd1);
   endtask

   initial begin
      // Reset state, sampled while rst_n is held low.
      #12;
      check_eq("rst_ready", 32'(cmd_ready), 32'd1);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_valid", 32'(rsp_valid), 32'd0);
      check_eq("rst_err", 32'(rsp_err), 32'd0);
      check_eq("rst_data", 32'(rsp_data), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_eq("post_rst_ready", 32'(cmd_ready), 32'd1);

      // Directed cases
      run_cmd(4'b1000, 5'd4, 0, "s8_l4");
      run_cmd(4'b0001, 5'd4, 0, "s1_l4");
      run_cmd(4'b1000, 5'd15, 0, "s8_l15a");
      run_cmd(4'b1000, 5'd15, 0, "s8_l15b");
      run_cmd(4'b0101, 5'd0, 0, "len0");
      run_cmd(4'b0101, 5'd17, 0, "len17");
      run_cmd(4'b0000, 5'd4, 0, "seed0");
      run_cmd(4'b0110, 5'd16, 0, "len16");
      run_cmd(4'b1011, 5'd6, 5, "hold5");
      run_cmd(4'b0011, 5'd0, 5, "hold5_err");

      // Abort on the 2nd RUN cycle of a len-8 command.
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_seed  = 4'b1101;
      cmd_len   = 5'd8;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      check_eq("abort_busy_pre", 32'(busy), 32'd1);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      check_eq("abort_busy", 32'(busy), 32'd0);
      check_eq("abort_ready", 32'(cmd_ready), 32'd1);
      check_eq("abort_valid", 32'(rsp_valid), 32'd0);
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         check_eq("abort_no_rsp", 32'(rsp_valid), 32'd0);
      end
      run_cmd(4'b1101, 5'd8, 0, "after_abort");

      // Asynchronous reset in the middle of RUN.
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_seed  = 4'b0111;
      cmd_len   = 5'd10;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      check_eq("mid_busy_pre", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_busy", 32'(busy), 32'd0);
      check_eq("mid_rst_valid", 32'(rsp_valid), 32'd0);
      check_eq("mid_rst_ready", 32'(cmd_ready), 32'd1);
      check_eq("mid_rst_data", 32'(rsp_data), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_eq("mid_post_ready", 32'(cmd_ready), 32'd1);
      check_eq("mid_post_busy", 32'(busy), 32'd0);
      run_cmd(4'b0111, 5'd10, 0, "after_rst");

      // Randomized commands, including out-of-range lengths and zero seeds.
      for (int n = 0; n < 30; n++) begin
         run_cmd(4'($urandom), 5'($urandom_range(0, 18)), int'($urandom_range(0, 3)), "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
